// File: rtl/streaming_argmax_top2.sv
// streaming_argmax_top2: serial top-2 arg-max for the classifier back end.
// A classification starts with a one-cycle start pulse while idle. NUM_LABELS
// scores are then accepted one per beat, and the block reports the winning
// label, the best and second-best scores, and their margin.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start              begin a classification (honoured only when idle)
//   in_valid/in_ready  score handshake; in_score belongs to label = beats so far
//   out_valid/out_ready result handshake; the result is held until accepted
//   out_label          index of the maximum (the lowest index wins ties)
//   out_max/out_second best and second-best scores (duplicates counted)
//   out_margin         out_max - out_second in N+1 bits, never negative
//   busy               high while accumulating or holding a result
module streaming_argmax_top2 #(
  parameter int unsigned N          = 8,
  parameter int unsigned NUM_LABELS = 10,
  parameter int unsigned LABEL_W    = 4,
  parameter int unsigned SIGNED     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_score,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] out_label,
  output logic [N-1:0]       out_max,
  output logic [N-1:0]       out_second,
  output logic [N:0]         out_margin,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  // Smallest representable score; this is the starting value for best and second.
  localparam logic [N-1:0]       MinVal  = (SIGNED != 0) ? {1'b1, {(N-1){1'b0}}} : '0;
  localparam logic [LABEL_W-1:0] LastIdx = LABEL_W'(NUM_LABELS - 1);

  function automatic logic gt(input logic [N-1:0] a, input logic [N-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Widening by one bit before subtracting keeps the margin free of overflow.
  function automatic logic [N:0] ext(input logic [N-1:0] a);
    return (SIGNED != 0) ? {a[N-1], a} : {1'b0, a};
  endfunction

  state_e               state_q, state_d;
  logic [LABEL_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]         best_q, best_d;
  logic [N-1:0]         second_q, second_d;
  logic [LABEL_W-1:0]   best_idx_q, best_idx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic [LABEL_W-1:0]   out_label_q, out_label_d;
  logic [N-1:0]         out_max_q, out_max_d;
  logic [N-1:0]         out_second_q, out_second_d;
  logic [N:0]           out_margin_q, out_margin_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    second_d     = second_q;
    best_idx_d   = best_idx_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    busy_d       = busy_q;
    out_label_d  = out_label_q;
    out_max_d    = out_max_q;
    out_second_d = out_second_q;
    out_margin_d = out_margin_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAccum;
          cnt_d      = '0;
          best_d     = MinVal;
          second_d   = MinVal;
          best_idx_d = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StAccum: begin
        if (in_valid && in_ready_q) begin
          // A score equal to best falls through to the second compare. This keeps
          // the earlier label and sets second to the tied value, so the margin is 0.
          if (gt(in_score, best_q)) begin
            second_d   = best_q;
            best_d     = in_score;
            best_idx_d = cnt_q;
          end else if (gt(in_score, second_q)) begin
            second_d = in_score;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d      = StDone;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            out_label_d  = best_idx_d;
            out_max_d    = best_d;
            out_second_d = second_d;
            out_margin_d = ext(best_d) - ext(second_d);
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      best_q       <= '0;
      second_q     <= '0;
      best_idx_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_label_q  <= '0;
      out_max_q    <= '0;
      out_second_q <= '0;
      out_margin_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      second_q     <= second_d;
      best_idx_q   <= best_idx_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      out_label_q  <= out_label_d;
      out_max_q    <= out_max_d;
      out_second_q <= out_second_d;
      out_margin_q <= out_margin_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_label  = out_label_q;
  assign out_max    = out_max_q;
  assign out_second = out_second_q;
  assign out_margin = out_margin_q;

endmodule

// File: doc/streaming_argmax_top2.md
Name: streaming_argmax_top2

Overview:
- Sequential classifier back end for the MLP output layer.
- Accepts NUM_LABELS output-neuron scores serially, one per beat, over a valid/ready handshake.
- Tracks the best and second-best scores and reports the winning label, both values and the confidence margin.
- Sits between the last layer's activation stage and the result consumer, e.g. the testbench scoreboard or a display.

Parameters:
N, 8, score width in bits; all N bits take part in every comparison.
NUM_LABELS, 10, number of scores per classification (>=1).
LABEL_W, 4, label/index width; must satisfy 2^LABEL_W >= NUM_LABELS.
SIGNED, 0, 0 = unsigned two's-complement-free compare; 1 = signed compare.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a classification; honoured only in IDLE
in_valid  input  1  in_score valid
in_ready  output  1  block accepts a score this cycle
in_score  input  N  score for label index = beats accepted so far
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
out_label  output  LABEL_W  index of the maximum score
out_max  output  N  maximum score
out_second  output  N  second-highest score, duplicates counted
out_margin  output  N+1  out_max - out_second, unsigned, always >= 0
busy  output  1  high in ACCUM or DONE

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; in_ready=0; out_valid=0; busy=0; out_label=0; out_max, out_second and out_margin = 0; beat counter=0.
- rst asserted mid-ACCUM or mid-DONE aborts the operation. The partial result is discarded, and the next cycle is IDLE with reset values.
- States:
  - IDLE: in_ready=0, out_valid=0. start=1 -> ACCUM. On entry, cnt=0, best=MIN, second=MIN, best_idx=0.
  - MIN is 0 when SIGNED=0, and -2^(N-1) when SIGNED=1.
  - ACCUM: in_ready=1. A beat is accepted when in_valid & in_ready; no beat is accepted while in_valid=0, and the counter holds.
  - Per accepted beat with score s at index cnt:
    - s > best (strict): second<=best, best<=s, best_idx<=cnt.
    - else if s > second: second<=s.
    - else: no change.
    - Then cnt<=cnt+1.
  - Ties: the lowest index wins the label. A score equal to best updates second to that value, so a tie gives margin 0.
  - Accepting the beat with cnt==NUM_LABELS-1 -> DONE. in_ready drops in the following cycle.
  - DONE: out_valid=1, busy=1, in_ready=0.
    - out_label, out_max, out_second and out_margin are registered and stable while out_valid=1.
    - out_valid & out_ready -> IDLE next cycle. If out_ready stays low, DONE holds indefinitely.
- start is ignored in ACCUM and DONE. A start in the same cycle the result is accepted is also ignored.
- Latency: out_valid rises the cycle after the last beat is accepted. Minimum classification time is 1 (start) + NUM_LABELS + 1 cycles.
- Back-to-back: result accept -> IDLE -> new start, so there is a minimum one-cycle gap.
- NUM_LABELS=1: out_second=MIN, and out_margin = score - MIN.
- Arithmetic: out_margin is computed in N+1 bits, sign-extended when SIGNED=1 and zero-extended when SIGNED=0, so it never overflows.
- Counter: cnt is LABEL_W bits wide and never wraps within an operation, because it is cleared on entry to ACCUM.

Test Plan:
1. N=8, SIGNED=0, scores [3,9,1,200,7,200,0,5,4,2] on consecutive beats -> out_label=3, out_max=200, out_second=200, out_margin=0; out_valid rises the cycle after beat 9 is accepted.
2. SIGNED=0, scores [0x80,0x7F,0,0,0,0,0,0,0,0] -> out_label=0, out_max=0x80, out_second=0x7F, out_margin=1. This proves the full N-bit compare, including the MSB.
3. SIGNED=1, scores [-5,-2,-128,-3,-2,-100,-7,-9,-1,-50] -> out_label=8, out_max=-1, out_second=-2, out_margin=1.
4. Handshake stress:
   - in_valid toggled randomly with scores 0..9 ascending -> out_label=9, out_max=9, out_second=8.
   - out_ready held low 20 cycles -> outputs stable and out_valid high throughout.
   - A start pulse during DONE is ignored.
5. rst asserted after 4 beats of a classification -> IDLE with all outputs 0. A fresh run of all-equal scores (10 x 0x42) -> out_label=0, out_margin=0.
6. Two back-to-back classifications, with out_ready high and start issued the cycle after acceptance -> each result is correct and independent, with no residue from the first run's best or second values.
